// File: rtl/segment_sample_counter.sv
// segment_sample_counter: collects a programmable window of segment samples,
// counts hits per segment (0..3) and reports the counts plus the most
// frequent segment (lowest index wins ties) at the end of each window.
module segment_sample_counter #(
    parameter int unsigned WIDTH = 31
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_start,
    input  logic [WIDTH:0]   in_window_length,
    input  logic             in_valid,
    input  logic [1:0]       in_segment_number,
    output logic [WIDTH:0]   out_count0,
    output logic [WIDTH:0]   out_count1,
    output logic [WIDTH:0]   out_count2,
    output logic [WIDTH:0]   out_count3,
    output logic [1:0]       out_max_segment,
    output logic             out_busy,
    output logic             out_done
);

    localparam int unsigned CW = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REDUCE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [WIDTH:0]  r_length;
    logic [WIDTH:0]  r_sample_cnt;
    logic [WIDTH:0]  r_work [4];

    logic            w_accept;
    logic [WIDTH:0]  w_sample_next;
    logic            w_last;
    logic [1:0]      w_max_seg;
    logic [WIDTH:0]  w_max_val;

    // Sample acceptance and end-of-window detection
    always_comb begin
        w_accept      = (r_state == S_COLLECT) && in_valid;
        w_sample_next = r_sample_cnt + CW'(1);
        w_last        = w_accept && (w_sample_next == r_length);
    end

    // State register
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a zero-length window skips straight to REDUCE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_start) begin
                    w_state_next = (in_window_length != '0) ? S_COLLECT : S_REDUCE;
                end
            end
            S_COLLECT: begin
                if (w_last) begin
                    w_state_next = S_REDUCE;
                end
            end
            S_REDUCE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Arg-max over working counters; strict compare keeps the lowest index on ties
    always_comb begin
        w_max_seg = 2'd0;
        w_max_val = r_work[0];
        for (int i = 1; i < 4; i++) begin
            if (r_work[i] > w_max_val) begin
                w_max_val = r_work[i];
                w_max_seg = 2'(i);
            end
        end
    end

    // Window length, sample counter and working counters
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_length     <= '0;
            r_sample_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                r_work[i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && in_start) begin
                r_length     <= in_window_length;
                r_sample_cnt <= '0;
                for (int i = 0; i < 4; i++) begin
                    r_work[i] <= '0;
                end
            end else if (w_accept) begin
                r_sample_cnt               <= w_sample_next;
                r_work[in_segment_number]  <= r_work[in_segment_number] + CW'(1);
            end
        end
    end

    // Registered results, published only on the REDUCE edge
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_count0      <= '0;
            out_count1      <= '0;
            out_count2      <= '0;
            out_count3      <= '0;
            out_max_segment <= 2'd0;
        end else if (r_state == S_REDUCE) begin
            out_count0      <= r_work[0];
            out_count1      <= r_work[1];
            out_count2      <= r_work[2];
            out_count3      <= r_work[3];
            out_max_segment <= w_max_seg;
        end
    end

    // Status flags: busy tracks the upcoming state, done marks the REDUCE edge
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_busy <= 1'b0;
            out_done <= 1'b0;
        end else begin
            out_busy <= (w_state_next != S_IDLE);
            out_done <= (r_state == S_REDUCE);
        end
    end

endmodule

// File: tb/tb_segment_sample_counter.sv
// Directed bench for segment_sample_counter with a result scoreboard.
module tb_segment_sample_counter;

    localparam int unsigned WIDTH = 31;

    logic             in_clock = 1'b0;
    logic             in_reset = 1'b0;
    logic             in_start = 1'b0;
    logic [WIDTH:0]   in_window_length = '0;
    logic             in_valid = 1'b0;
    logic [1:0]       in_segment_number = 2'd0;
    logic [WIDTH:0]   out_count0;
    logic [WIDTH:0]   out_count1;
    logic [WIDTH:0]   out_count2;
    logic [WIDTH:0]   out_count3;
    logic [1:0]       out_max_segment;
    logic             out_busy;
    logic             out_done;

    segment_sample_counter #(.WIDTH(WIDTH)) dut (
        .in_clock          (in_clock),
        .in_reset          (in_reset),
        .in_start          (in_start),
        .in_window_length  (in_window_length),
        .in_valid          (in_valid),
        .in_segment_number (in_segment_number),
        .out_count0        (out_count0),
        .out_count1        (out_count1),
        .out_count2        (out_count2),
        .out_count3        (out_count3),
        .out_max_segment   (out_max_segment),
        .out_busy          (out_busy),
        .out_done          (out_done)
    );

    always #5 in_clock = ~in_clock;

    typedef struct packed {
        logic        v;
        logic [1:0]  s;
        logic        st;
    } samp_t;

    typedef struct packed {
        logic [3:0][WIDTH:0] c;
        logic [1:0]          mx;
    } res_t;

    samp_t stim[$];
    res_t  sb[$];
    res_t  last_res;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    // Reference result: count valid samples up to len, then find the top value
    // and pick the lowest index holding it.
    function automatic res_t model(input logic [WIDTH:0] len);
        res_t           r;
        logic [WIDTH:0] n;
        logic [WIDTH:0] maxv;
        r    = '0;
        n    = '0;
        maxv = '0;
        foreach (stim[i]) begin
            if (stim[i].v && (n < len)) begin
                r.c[stim[i].s] = r.c[stim[i].s] + 1;
                n = n + 1;
            end
        end
        for (int i = 0; i < 4; i++) if (r.c[i] > maxv) maxv = r.c[i];
        for (int i = 3; i >= 0; i--) if (r.c[i] == maxv) r.mx = 2'(i);
        return r;
    endfunction

    task automatic start_win(input logic [WIDTH:0] len);
        in_start         = 1'b1;
        in_window_length = len;
        tick();
        in_start = 1'b0;
        chk("busy_after_start", 32'(out_busy), 32'd1);
    endtask

    task automatic feed(input string tag);
        foreach (stim[i]) begin
            in_valid          = stim[i].v;
            in_segment_number = stim[i].s;
            in_start          = stim[i].st;
            if (stim[i].st) in_window_length = 32'd1;
            tick();
            if (i < 12) begin
                chk({tag, "_no_done"}, 32'(out_done), 32'd0);
                chk({tag, "_busy"}, 32'(out_busy), 32'd1);
                chk({tag, "_hold_c0"}, out_count0, last_res.c[0]);
                chk({tag, "_hold_c1"}, out_count1, last_res.c[1]);
            end
        end
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int   lat;
        res_t e;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (out_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (lat != 0) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_c0"}, out_count0, e.c[0]);
                chk({tag, "_c1"}, out_count1, e.c[1]);
                chk({tag, "_c2"}, out_count2, e.c[2]);
                chk({tag, "_c3"}, out_count3, e.c[3]);
                chk({tag, "_max"}, 32'(out_max_segment), 32'(e.mx));
                chk({tag, "_busy_low"}, 32'(out_busy), 32'd0);
                last_res = e;
            end
            tick();
            chk({tag, "_done_pulse"}, 32'(out_done), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lfsr;
        logic [2:0]  r;
        samp_t       sp;

        last_res = '0;

        // Reset values
        in_reset = 1'b1;
        tick();
        tick();
        chk("rst_c0", out_count0, 32'd0);
        chk("rst_c3", out_count3, 32'd0);
        chk("rst_max", 32'(out_max_segment), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_done", 32'(out_done), 32'd0);
        in_reset = 1'b0;
        tick();

        // Basic window: 0,1,1,2,1,2,1,0
        stim.delete();
        foreach (stim[i]) ;
        for (int i = 0; i < 8; i++) begin
            sp.v = 1'b1; sp.st = 1'b0;
            case (i)
                0, 7:    sp.s = 2'd0;
                3, 5:    sp.s = 2'd2;
                default: sp.s = 2'd1;
            endcase
            stim.push_back(sp);
        end
        sb.push_back(model(32'd8));
        start_win(32'd8);
        feed("basic");
        wait_done("basic", 1);
        chk("basic_c1_const", out_count1, 32'd4);
        chk("basic_max_const", 32'(out_max_segment), 32'd1);

        // Valid gaps: 3,x,3,x,0,x,3
        stim.delete();
        for (int i = 0; i < 7; i++) begin
            sp.v  = (i % 2 == 0);
            sp.st = 1'b0;
            sp.s  = (i == 4) ? 2'd0 : ((i % 2 == 0) ? 2'd3 : 2'd1);
            stim.push_back(sp);
        end
        sb.push_back(model(32'd4));
        start_win(32'd4);
        feed("gaps");
        wait_done("gaps", 1);
        chk("gaps_c3_const", out_count3, 32'd3);

        // Zero length with valid held high, then idle samples are discarded
        stim.delete();
        in_valid          = 1'b1;
        in_segment_number = 2'd2;
        sb.push_back(model(32'd0));
        start_win(32'd0);
        wait_done("zero", 1);
        tick();
        tick();
        chk("idle_busy", 32'(out_busy), 32'd0);
        chk("idle_c3", out_count3, 32'd0);
        in_valid = 1'b0;

        // Tie with an ignored mid-window start
        stim.delete();
        for (int i = 0; i < 6; i++) begin
            sp.v  = 1'b1;
            sp.s  = (i % 2 == 0) ? 2'd2 : 2'd0;
            sp.st = (i == 2);
            stim.push_back(sp);
        end
        sb.push_back(model(32'd6));
        start_win(32'd6);
        feed("tie");
        wait_done("tie", 1);
        chk("tie_max_const", 32'(out_max_segment), 32'd0);

        // Reset mid-window: partial window is lost, outputs clear immediately
        stim.delete();
        for (int i = 0; i < 5; i++) begin
            sp.v = 1'b1; sp.s = 2'(i); sp.st = 1'b0;
            stim.push_back(sp);
        end
        start_win(32'd10);
        feed("prerst");
        #2;
        in_reset = 1'b1;
        #1;
        chk("midrst_c0", out_count0, 32'd0);
        chk("midrst_c2", out_count2, 32'd0);
        chk("midrst_busy", 32'(out_busy), 32'd0);
        chk("midrst_done", 32'(out_done), 32'd0);
        tick();
        chk("midrst_done2", 32'(out_done), 32'd0);
        #2;
        in_reset = 1'b0;
        tick();
        last_res = '0;
        stim.delete();
        for (int i = 0; i < 2; i++) begin
            sp.v = 1'b1; sp.s = 2'd1; sp.st = 1'b0;
            stim.push_back(sp);
        end
        sb.push_back(model(32'd2));
        start_win(32'd2);
        feed("postrst");
        wait_done("postrst", 1);
        chk("postrst_c1_const", out_count1, 32'd2);

        // Weighted chooser (2,4,2,0), seed 1, window of 8000
        stim.delete();
        lfsr = 16'd1;
        for (int i = 0; i < 8000; i++) begin
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            r    = lfsr[2:0];
            sp.v = 1'b1; sp.st = 1'b0;
            if (r < 3'd2)      sp.s = 2'd0;
            else if (r < 3'd6) sp.s = 2'd1;
            else               sp.s = 2'd2;
            stim.push_back(sp);
        end
        sb.push_back(model(32'd8000));
        start_win(32'd8000);
        feed("chain");
        wait_done("chain", 1);
        chk("chain_c3_zero", out_count3, 32'd0);
        chk("chain_max_is1", 32'(out_max_segment), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segment_sample_counter.md
# segment_sample_counter

Hardware consumer for the `RandomChoose` segment selector. It collects a programmable window of `out_segment_number` samples and counts how often each of the four segments was picked. At the end of the window it reports the four counts and the most-frequent segment. It sits downstream of `RandomChoose` in the MCMC solver datapath and gives an on-chip check of the chooser's empirical distribution against the programmed weights.

## Interface
Parameters:
- `WIDTH`, default 31: MSB index of the window length and of all count values. Data buses are `[WIDTH:0]`.

Ports:
- `in_clock`  input  1  sole clock; all state updates on rising edge.
- `in_reset`  input  1  asynchronous, active-high reset.
- `in_start`  input  1  request to begin a window; honoured only in IDLE.
- `in_window_length`  input  WIDTH+1  number of valid samples to collect; latched on an accepted start.
- `in_valid`  input  1  `in_segment_number` carries a sample this cycle.
- `in_segment_number`  input  2  sampled segment index (0..3), from `RandomChoose`.
- `out_count0`..`out_count3`  output  WIDTH+1 each  per-segment counts of the last completed window.
- `out_max_segment`  output  2  segment with the largest count in the last window; a tie resolves to the lowest index.
- `out_busy`  output  1  high while a window is collecting or reducing.
- `out_done`  output  1  one-cycle pulse when new results are presented.

## Operation
- States: IDLE, COLLECT, REDUCE.
- **IDLE**
  - `in_start`=1 latches `in_window_length` into `length_q`, clears the sample counter and the four working counters.
  - Next state is COLLECT if `length_q`≠0, otherwise REDUCE.
- **COLLECT**
  - Each edge with `in_valid`=1 increments `work[in_segment_number]` and the sample counter by 1.
  - When the accepted sample brings the sample counter to `length_q`, the next state is REDUCE.
  - `in_valid`=0 holds all working state.
- **REDUCE**, one cycle:
  - Copies `work0..3` to `out_count0..3`.
  - Computes `out_max_segment` by comparing with strict greater-than in index order 0,1,2,3, so the lowest index wins ties.
  - Pulses `out_done`, then returns to IDLE.
- Width rules:
  - Working counters and the sample counter are WIDTH+1 bits.
  - No count can exceed `length_q`, so no overflow or saturation logic exists.
- Result outputs hold their previous values throughout COLLECT and change only at the REDUCE edge.
- `in_start` in COLLECT or REDUCE is ignored and not queued.
- Samples with `in_valid`=1 while in IDLE or REDUCE are discarded.
- Reset, at any time including mid-window, does all of the following:
  - State goes to IDLE.
  - All counters, `length_q` and every output go to 0.
  - The partial window is lost.

## Timing
- Reset values: `out_count0..3`=0, `out_max_segment`=0, `out_busy`=0, `out_done`=0.
- All outputs are registered, with no combinational input-to-output path.
- Start accepted at edge T:
  - `out_busy`=1 from T.
  - The first countable sample is the one present at edge T+1.
- Last (Nth) sample accepted at edge K:
  - REDUCE runs during cycle K→K+1.
  - At edge K+1, results update, `out_done`=1 for exactly one cycle and `out_busy`=0.
- `out_busy` is high from edge T up to edge K+1, covering both COLLECT and REDUCE.
- Window length 0: start at edge T → `out_done` and all-zero results at edge T+1.
- Back-to-back windows: an `in_start` sampled in the cycle where `out_done`=1 is accepted, because the block is in IDLE.
- Minimum window period is N+2 cycles with continuous valid.

## Test plan
- **Basic window:** reset, then start with length 8, then valid every cycle with segments 0,1,1,2,1,2,1,0.
  - Counts must be 2,4,2,0 and `out_max_segment`=1.
  - `out_done` must pulse one cycle after the edge that accepts the 8th sample.
- **Valid gaps:** length 4 with `in_valid` toggling 1,0,1,0…, segments 3,x,3,x,0,x,3.
  - Counts must be 1,0,0,3 and `out_max_segment`=3.
  - Invalid cycles must not be counted.
- **Zero length and idle samples:** start with length 0 while `in_valid`=1 → `out_done` at T+1, all counts 0, max 0, `out_busy` high for exactly one cycle.
- **Tie and ignored start:** length 6 with segments 2,0,2,0,2,0; pulse `in_start` with length 1 mid-window.
  - Counts must be 3,0,3,0 and `out_max_segment`=0.
  - The window must still end after 6 samples.
- **Reset mid-window:** length 10; after 5 samples assert `in_reset` asynchronously between edges.
  - Outputs go to 0 immediately, with no `out_done`.
  - After release, a fresh length-2 window of segments 1,1 must give counts 0,2,0,0.
- **Chained with RandomChoose:** weights 2,4,2,0, seed 1, window 8000 → count3 must be exactly 0 and count1 must be the maximum.
